lbi_tag_verifier: RTL and testbench
===================================

Name: lbi_tag_verifier

Overview:
- Receiving end of the LBI tag path: compares the 140-entry, 6-bit tag computed locally by the LBI matrix core against the expected tag received from the link.
- The expected tag arrives as a valid/ready word stream. The computed tag arrives as one 840-bit bus qualified by a single-cycle valid pulse.
- After both are held, the block compares entry by entry and reports match/mismatch, the mismatch count and the first mismatching index.

Parameters:
NUM_ROW, 140, number of tag entries
ENTRY_W, 6, bits per entry (mod-64 sum of left/right products)
WORD_W, 24, stream word width; entries per word EPW = WORD_W/ENTRY_W = 4
NUM_WORDS, 35, NUM_ROW/EPW; must divide evenly (elaboration check)
TIMEOUT, 4096, max cycles in COLLECT before abort

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  arms a new verification; honoured only in IDLE or DONE
tag_in  in  WORD_W  expected-tag word; entry EPW*k+j at bits [j*ENTRY_W +: ENTRY_W] of word k
tag_in_vld  in  1  tag_in valid
tag_in_rdy  out  1  block accepts tag_in this cycle
msgmat_in  in  NUM_ROW*ENTRY_W  computed tag; entry i at [i*6 +: 6]
msgmat_invld  in  1  single-cycle pulse qualifying msgmat_in
busy  out  1  state is COLLECT or COMPARE
result_vld  out  1  one-cycle pulse: result fields are valid
result_match  out  1  all entries equal and no timeout
mismatch_cnt  out  8  number of unequal entries (0..140)
first_mismatch_idx  out  8  lowest unequal entry index; 8'hFF if none
err_timeout  out  1  last verification aborted by timeout

Behaviour:
- States: IDLE, COLLECT, COMPARE, DONE. Reset forces IDLE from any state, including mid-COMPARE. Reset clears both buffers, counters and all outputs to 0, except first_mismatch_idx, which resets to 8'hFF.
- IDLE/DONE + start -> COLLECT next cycle.
  - On entry: word counter=0, got_calc=0, timeout counter=0, result fields cleared (first_mismatch_idx=8'hFF).
  - start in COLLECT/COMPARE is ignored.
- COLLECT:
  - tag_in_rdy = (word counter < NUM_WORDS), registered-state based; it has no combinational path from tag_in_vld.
  - A transfer occurs on tag_in_vld & tag_in_rdy: the word is stored at slot [word counter] and the counter increments. Gaps in vld are allowed.
  - msgmat_invld with got_calc=0 latches msgmat_in and sets got_calc. Further pulses while got_calc=1 are ignored, as are pulses in any state other than COLLECT, including the start cycle itself.
  - Tag words and the computed-tag pulse may arrive in either order or in the same cycle.
  - Exit to COMPARE the cycle after word counter==NUM_WORDS and got_calc==1 both hold.
  - The timeout counter increments every COLLECT cycle. If it reaches TIMEOUT-1 without completion -> DONE with err_timeout=1, result_match=0, mismatch_cnt=0, first_mismatch_idx=8'hFF.
- COMPARE:
  - One word per cycle, index c=0..NUM_WORDS-1, so exactly NUM_WORDS (35) cycles.
  - Each cycle compares EPW entries: the received word c against computed entries EPW*c..EPW*c+EPW-1.
  - mismatch_cnt += popcount of unequal entries; it cannot overflow (max 140).
  - first_mismatch_idx is written only while it is still 8'hFF, with the lowest unequal index in that word.
  - After c==NUM_WORDS-1 -> DONE.
- DONE:
  - result_vld=1 for exactly the first DONE cycle.
  - result_match = (mismatch_cnt==0) & ~err_timeout.
  - Result fields hold until the next accepted start or reset. The block remains in DONE until start.
- Latency from the last required input (final tag word or msgmat_invld) to result_vld: 1 + 35 + 1 = 37 cycles.
- busy=1 exactly in COLLECT and COMPARE. tag_in_rdy=0 outside COLLECT.

Test Plan:
- Exact match: start; stream 35 words equal to the packed computed tag; msgmat_invld at word 10 -> result_vld 37 cycles after the last word, result_match=1, mismatch_cnt=0, first_mismatch_idx=8'hFF.
- Two mismatches: entries 5 and 137 differ (word 1 lane 1; word 34 lane 1) -> result_match=0, mismatch_cnt=2, first_mismatch_idx=5.
- All wrong plus ordering: tag words all 0 and computed tag all 6'h3F; msgmat_invld before start (ignored), then again after all 35 words; tag_in_vld toggling 1-0-1 -> only 35 transfers counted, mismatch_cnt=140, first_mismatch_idx=0.
- Timeout: TIMEOUT=64, send 20 words and no msgmat_invld -> result_vld 64 cycles after entering COLLECT, err_timeout=1, result_match=0.
- Reset mid-COMPARE: assert reset for 1 cycle at compare word 17 -> next cycle IDLE, busy=0, result_vld stays 0, first_mismatch_idx=8'hFF; a new start-run then completes normally.
- start during COLLECT and a second msgmat_invld pulse with different data -> both ignored; comparison uses the first latched tag, word counter unaffected.

Source files
------------

// File: rtl/lbi_tag_verifier.sv
// LBI tag verifier: collects the expected tag from the link stream and the locally
// computed tag, then compares them one stream word per cycle and reports the outcome.
module lbi_tag_verifier #(
  parameter int NUM_ROW = 140,
  parameter int ENTRY_W = 6,
  parameter int WORD_W  = 24,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_W-1:0]          tag_in,
  input  logic                       tag_in_vld,
  output logic                       tag_in_rdy,
  input  logic [NUM_ROW*ENTRY_W-1:0] msgmat_in,
  input  logic                       msgmat_invld,
  output logic                       busy,
  output logic                       result_vld,
  output logic                       result_match,
  output logic [7:0]                 mismatch_cnt,
  output logic [7:0]                 first_mismatch_idx,
  output logic                       err_timeout
);

  localparam int EPW       = WORD_W / ENTRY_W;
  localparam int NUM_WORDS = NUM_ROW / EPW;
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int CIDX_W    = $clog2(NUM_WORDS);
  localparam int TCNT_W    = $clog2(TIMEOUT);
  localparam int POP_W     = $clog2(EPW + 1);

  localparam logic [WCNT_W-1:0] WORDS_FULL = WCNT_W'(NUM_WORDS);
  localparam logic [CIDX_W-1:0] CIDX_LAST  = CIDX_W'(NUM_WORDS - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT - 1);
  localparam logic [7:0]        NO_IDX     = 8'hFF;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  generate
    if (NUM_WORDS * EPW != NUM_ROW || EPW * ENTRY_W != WORD_W) begin : g_bad_geometry
      $error("lbi_tag_verifier: NUM_ROW must split evenly into WORD_W-wide words");
    end
  endgenerate

  logic [1:0]        state;
  logic [WCNT_W-1:0] wcnt;
  logic [CIDX_W-1:0] cidx;
  logic [TCNT_W-1:0] tcnt;
  logic              got_calc;
  logic [WORD_W-1:0] tag_buf  [NUM_WORDS];
  // The computed tag is held word-aligned with the stream so both sides index the same way.
  logic [WORD_W-1:0] calc_buf [NUM_WORDS];

  logic [EPW-1:0]   lane_ne;
  logic [POP_W-1:0] lane_pop;
  logic [7:0]       lane_first;
  logic [7:0]       cnt_sum;

  assign busy       = (state == S_COLLECT) || (state == S_COMPARE);
  assign tag_in_rdy = (state == S_COLLECT) && (wcnt < WORDS_FULL);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    lane_ne    = '0;
    lane_pop   = '0;
    lane_first = NO_IDX;
    for (int j = 0; j < EPW; j++) begin
      lane_ne[j] = tag_buf[cidx][j*ENTRY_W +: ENTRY_W] != calc_buf[cidx][j*ENTRY_W +: ENTRY_W];
      lane_pop   = lane_pop + POP_W'(lane_ne[j]);
    end
    // Walk lanes from the top down so the lowest unequal lane wins.
    for (int j = EPW - 1; j >= 0; j--) begin
      if (lane_ne[j]) lane_first = 8'(EPW * int'(cidx) + j);
    end
    cnt_sum = mismatch_cnt + 8'(lane_pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      cidx     <= '0;
      tcnt     <= '0;
      got_calc <= 1'b0;
      // NOTE: the buffers are cleared on reset so a stale tag can never leak into a later compare.
      for (int k = 0; k < NUM_WORDS; k++) begin
        tag_buf[k]  <= '0;
        calc_buf[k] <= '0;
      end
      result_vld         <= 1'b0;
      result_match       <= 1'b0;
      mismatch_cnt       <= '0;
      first_mismatch_idx <= NO_IDX;
      err_timeout        <= 1'b0;
    end else begin
      result_vld <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state              <= S_COLLECT;
            wcnt               <= '0;
            cidx               <= '0;
            tcnt               <= '0;
            got_calc           <= 1'b0;
            result_match       <= 1'b0;
            mismatch_cnt       <= '0;
            first_mismatch_idx <= NO_IDX;
            err_timeout        <= 1'b0;
          end
        end

        S_COLLECT: begin
          if (tag_in_vld && tag_in_rdy) begin
            tag_buf[wcnt] <= tag_in;
            wcnt          <= wcnt + WCNT_W'(1);
          end
          if (msgmat_invld && !got_calc) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
              calc_buf[k] <= msgmat_in[k*WORD_W +: WORD_W];
            end
            got_calc <= 1'b1;
          end
          tcnt <= tcnt + TCNT_W'(1);
          // Completion takes priority over a timeout expiring in the same cycle.
          if (wcnt == WORDS_FULL && got_calc) begin
            state <= S_COMPARE;
            cidx  <= '0;
          end else if (tcnt == TCNT_LAST) begin
            state              <= S_DONE;
            result_vld         <= 1'b1;
            result_match       <= 1'b0;
            mismatch_cnt       <= '0;
            first_mismatch_idx <= NO_IDX;
            err_timeout        <= 1'b1;
          end
        end

        S_COMPARE: begin
          mismatch_cnt <= cnt_sum;
          if (first_mismatch_idx == NO_IDX) first_mismatch_idx <= lane_first;
          cidx <= cidx + CIDX_W'(1);
          if (cidx == CIDX_LAST) begin
            state        <= S_DONE;
            result_vld   <= 1'b1;
            result_match <= (cnt_sum == 8'd0);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbi_tag_verifier.sv
// Scoreboard bench for lbi_tag_verifier: randomized runs against an entry-level reference
// model, with expected results queued by the driver and checked by an independent monitor.
module tb_lbi_tag_verifier;

  localparam int NUM_ROW   = 140;
  localparam int ENTRY_W   = 6;
  localparam int WORD_W    = 24;
  localparam int EPW       = 4;
  localparam int NUM_WORDS = 35;
  localparam int TIMEOUT   = 64;
  localparam int LATENCY   = 37;
  localparam int MAX_GAPS  = 15;

  typedef struct {
    bit     match;
    int     cnt;
    int     idx;
    bit     tmo;
    longint at;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start;
  logic [WORD_W-1:0]          tag_in;
  logic                       tag_in_vld;
  logic                       tag_in_rdy;
  logic [NUM_ROW*ENTRY_W-1:0] msgmat_in;
  logic                       msgmat_invld;
  logic                       busy;
  logic                       result_vld;
  logic                       result_match;
  logic [7:0]                 mismatch_cnt;
  logic [7:0]                 first_mismatch_idx;
  logic                       err_timeout;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  exp_t   exp_q[$];
  bit [ENTRY_W-1:0] tag_e  [NUM_ROW];
  bit [ENTRY_W-1:0] calc_e [NUM_ROW];

  lbi_tag_verifier #(.NUM_ROW(NUM_ROW), .ENTRY_W(ENTRY_W), .WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .tag_in(tag_in), .tag_in_vld(tag_in_vld), .tag_in_rdy(tag_in_rdy),
    .msgmat_in(msgmat_in), .msgmat_invld(msgmat_invld),
    .busy(busy), .result_vld(result_vld), .result_match(result_match),
    .mismatch_cnt(mismatch_cnt), .first_mismatch_idx(first_mismatch_idx),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WORD_W-1:0] pack_word(input int k);
    logic [WORD_W-1:0] w;
    for (int j = 0; j < EPW; j++) w[j*ENTRY_W +: ENTRY_W] = tag_e[EPW*k + j];
    return w;
  endfunction

  function automatic logic [NUM_ROW*ENTRY_W-1:0] pack_calc();
    logic [NUM_ROW*ENTRY_W-1:0] b;
    for (int i = 0; i < NUM_ROW; i++) b[i*ENTRY_W +: ENTRY_W] = calc_e[i];
    return b;
  endfunction

  // Reference: plain entry-by-entry comparison of the two tags.
  task automatic model(output int cnt, output int idx);
    cnt = 0;
    idx = 255;
    for (int i = 0; i < NUM_ROW; i++) begin
      if (tag_e[i] != calc_e[i]) begin
        cnt++;
        if (idx == 255) idx = i;
      end
    end
  endtask

  task automatic fill(input int mismatch_pct);
    for (int i = 0; i < NUM_ROW; i++) begin
      calc_e[i] = ENTRY_W'($urandom);
      tag_e[i]  = calc_e[i];
      if ($urandom_range(99) < mismatch_pct) tag_e[i] = calc_e[i] ^ ENTRY_W'($urandom_range(63, 1));
    end
  endtask

  task automatic wait_result(input int cnt);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("result_wait_expired", 0, 1);
      exp_q.delete();
    end
    repeat (2) tick();
    check("hold_mismatch_cnt", mismatch_cnt, cnt);
  endtask

  task automatic do_run(input int calc_at, input int gap_pct, input bit pre_pulse,
                        input bit noise, input int abort_word);
    logic [NUM_ROW*ENTRY_W-1:0] calc_bus;
    int     w, gaps, cnt, idx;
    bit     calc_sent, v;
    longint last;
    exp_t   e;
    model(cnt, idx);
    calc_bus = pack_calc();
    if (pre_pulse) begin
      msgmat_invld = 1'b1;
      msgmat_in    = ~calc_bus;
      tick();
    end
    start = 1'b1;
    tick();
    start        = 1'b0;
    msgmat_invld = 1'b0;
    check("busy_collect", busy, 1);
    check("cleared_idx_on_start", first_mismatch_idx, 255);
    w = 0; gaps = 0; calc_sent = 1'b0; last = 0;
    while (w < NUM_WORDS || !calc_sent) begin
      v = (w < NUM_WORDS);
      if (v && gaps < MAX_GAPS && $urandom_range(99) < gap_pct) begin
        v = 1'b0;
        gaps++;
      end
      tag_in_vld   = v;
      tag_in       = v ? pack_word(w) : WORD_W'($urandom);
      msgmat_invld = 1'b0;
      if (!calc_sent && w >= calc_at) begin
        msgmat_invld = 1'b1;
        msgmat_in    = calc_bus;
        calc_sent    = 1'b1;
        last         = cyc;
      end else if (noise && calc_sent && $urandom_range(3) == 0) begin
        msgmat_invld = 1'b1;
        msgmat_in    = ~calc_bus;
        start        = 1'b1;
      end
      if (v && w == NUM_WORDS - 1) last = cyc;
      tick();
      start = 1'b0;
      if (v) w++;
    end
    tag_in_vld   = 1'b0;
    msgmat_invld = 1'b0;
    check("rdy_low_when_full", tag_in_rdy, 0);
    if (abort_word >= 0) begin
      repeat (abort_word + 1) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_rdy", tag_in_rdy, 0);
      check("abort_result_vld", result_vld, 0);
      check("abort_idx", first_mismatch_idx, 255);
      check("abort_cnt", mismatch_cnt, 0);
      repeat (LATENCY) tick();
      return;
    end
    e.match = (cnt == 0);
    e.cnt   = cnt;
    e.idx   = idx;
    e.tmo   = 1'b0;
    e.at    = last + LATENCY;
    exp_q.push_back(e);
    wait_result(cnt);
  endtask

  task automatic do_timeout(input int nwords);
    exp_t   e;
    longint s;
    fill(0);
    s     = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      tag_in_vld = 1'b1;
      tag_in     = pack_word(k);
      tick();
    end
    tag_in_vld = 1'b0;
    e.match = 1'b0;
    e.cnt   = 0;
    e.idx   = 255;
    e.tmo   = 1'b1;
    e.at    = s + 1 + TIMEOUT;
    exp_q.push_back(e);
    wait_result(0);
    check("timeout_flag_holds", err_timeout, 1);
  endtask

  // Monitor: independent of the driver, consumes one expectation per result pulse.
  always @(negedge clk) begin
    exp_t e;
    if (result_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_vld", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result_cycle", cyc, e.at);
        check("result_match", result_match, e.match);
        check("mismatch_cnt", mismatch_cnt, e.cnt);
        check("first_mismatch_idx", first_mismatch_idx, e.idx);
        check("err_timeout", err_timeout, e.tmo);
        check("busy_in_done", busy, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; tag_in = '0; tag_in_vld = 1'b0;
    msgmat_in = '0; msgmat_invld = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_rdy", tag_in_rdy, 0);
    check("reset_result_vld", result_vld, 0);
    check("reset_match", result_match, 0);
    check("reset_cnt", mismatch_cnt, 0);
    check("reset_idx", first_mismatch_idx, 255);
    check("reset_timeout", err_timeout, 0);
    reset = 1'b0;
    tick();

    fill(0);
    do_run(10, 0, 1'b0, 1'b0, -1);

    fill(0);
    tag_e[5]   = calc_e[5] ^ 6'h2A;
    tag_e[137] = calc_e[137] ^ 6'h01;
    do_run(0, 0, 1'b0, 1'b0, -1);

    for (int i = 0; i < NUM_ROW; i++) begin
      tag_e[i]  = '0;
      calc_e[i] = 6'h3F;
    end
    do_run(NUM_WORDS, 30, 1'b1, 1'b0, -1);

    do_timeout(20);

    fill(10);
    do_run(5, 10, 1'b0, 1'b0, 17);
    fill(5);
    do_run(20, 10, 1'b0, 1'b0, -1);

    fill(5);
    do_run(3, 10, 1'b0, 1'b1, -1);

    for (int r = 0; r < 6; r++) begin
      case (r % 4)
        0: fill(0);
        1: fill(3);
        2: fill(20);
        default: fill(60);
      endcase
      do_run($urandom_range(NUM_WORDS), 15, 1'($urandom_range(1)), 1'($urandom_range(1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
